// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter_checker slice: FSM state encoding,
// default bus widths and the width of the small run/miss counters.
package counter_checker_pkg;

    // HUNT: looking for a clean run of +1 steps. CHECK: locked, counting errors.
    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERR_W = 16;

    // run/miss thresholds are limited to 1..15, so four bits suffice.
    localparam int CNT_W = 4;

endpackage

// File: rtl/counter_checker_if.sv
// Sink-side bundle of the counter link: sampled count and controls in,
// lock/error status out. The master drives the stream, the slave checks it.
interface counter_checker_if
    import counter_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) ();

    logic [WIDTH-1:0] cmpt_in;
    logic             sample_en;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic             wrap_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [WIDTH-1:0] expected;

    modport master (
        output cmpt_in, sample_en, clr_err,
        input  locked, err_pulse, wrap_pulse, err_cnt, expected
    );

    modport slave (
        input  cmpt_in, sample_en, clr_err,
        output locked, err_pulse, wrap_pulse, err_cnt, expected
    );

endinterface

// File: rtl/counter_checker_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment leaves the counter at 1 so that the concurrent event is not lost.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] cnt_reg;

    // Clear has priority over hold; increment stops at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= inc ? W'(1) : '0;
        end else if (inc && (cnt_reg != MAX_VAL)) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/counter_checker.sv
// Receive-side checker for a free-running count stream. Every enabled sample
// must equal the previous one plus 1 (modulo 2^WIDTH). LOCK_CNT consecutive
// good steps acquire lock; UNLOCK_CNT consecutive bad steps while locked drop
// it. Mismatches seen while locked are pulsed and counted (saturating).
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = DEF_ERR_W
) (
    input logic              clk,
    input logic              rst,
    counter_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] LOCK_TGT   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_TGT = CNT_W'(UNLOCK_CNT);

    state_t           state_reg, state_next;
    logic             have_prev_reg;
    logic [CNT_W-1:0] run_reg, run_next;
    logic [CNT_W-1:0] miss_reg, miss_next;
    logic [WIDTH-1:0] expected_reg;
    logic             err_pulse_reg, err_pulse_next;
    logic             wrap_pulse_reg, wrap_pulse_next;
    logic             err_inc;
    logic             match;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] miss_inc;
    logic [ERR_W-1:0] err_cnt;

    // The very first sample after reset has nothing to compare against.
    assign match    = have_prev_reg && (bus.cmpt_in == expected_reg);
    assign run_inc  = run_reg + CNT_W'(1);
    assign miss_inc = miss_reg + CNT_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: lock when the run completes, unlock when misses pile up.
    always_comb begin
        state_next = state_reg;
        if (bus.sample_en) begin
            case (state_reg)
                ST_HUNT: begin
                    if (match && (run_inc == LOCK_TGT)) begin
                        state_next = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!match && (miss_inc == UNLOCK_TGT)) begin
                        state_next = ST_HUNT;
                    end
                end
                default: state_next = ST_HUNT;
            endcase
        end
    end

    // Per-state actions: run/miss bookkeeping, pulses and error increment.
    always_comb begin
        run_next        = run_reg;
        miss_next       = miss_reg;
        err_pulse_next  = 1'b0;
        wrap_pulse_next = 1'b0;
        err_inc         = 1'b0;
        if (bus.sample_en) begin
            case (state_reg)
                ST_HUNT: begin
                    if (match) begin
                        if (run_inc == LOCK_TGT) begin
                            run_next  = '0;
                            miss_next = '0;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        miss_next       = '0;
                        wrap_pulse_next = (bus.cmpt_in == '0);
                    end else begin
                        err_pulse_next = 1'b1;
                        err_inc        = 1'b1;
                        if (miss_inc == UNLOCK_TGT) begin
                            miss_next = '0;
                            run_next  = '0;
                        end else begin
                            miss_next = miss_inc;
                        end
                    end
                end
                default: begin
                    run_next  = '0;
                    miss_next = '0;
                end
            endcase
        end
    end

    // Datapath: every enabled sample re-anchors the expected value.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_prev_reg  <= 1'b0;
            run_reg        <= '0;
            miss_reg       <= '0;
            expected_reg   <= '0;
            err_pulse_reg  <= 1'b0;
            wrap_pulse_reg <= 1'b0;
        end else begin
            run_reg        <= run_next;
            miss_reg       <= miss_next;
            err_pulse_reg  <= err_pulse_next;
            wrap_pulse_reg <= wrap_pulse_next;
            if (bus.sample_en) begin
                expected_reg  <= bus.cmpt_in + WIDTH'(1);
                have_prev_reg <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (bus.clr_err),
        .cnt (err_cnt)
    );

    assign bus.locked     = (state_reg == ST_CHECK);
    assign bus.err_pulse  = err_pulse_reg;
    assign bus.wrap_pulse = wrap_pulse_reg;
    assign bus.err_cnt    = err_cnt;
    assign bus.expected   = expected_reg;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker. Instance A (LOCK 4 / UNLOCK 2 / 16-bit
// errors) is checked against a behavioural model through a scoreboard queue;
// instance B (UNLOCK 15, 4-bit errors) covers saturation and mid-run reset.
module tb_counter_checker;

    localparam int A_LOCK   = 4;
    localparam int A_UNLOCK = 2;

    typedef struct packed {
        logic        locked;
        logic        err_pulse;
        logic        wrap_pulse;
        logic [15:0] err_cnt;
        logic [7:0]  expected;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    counter_checker_if #(.WIDTH(8), .ERR_W(16)) bus_a ();
    counter_checker_if #(.WIDTH(8), .ERR_W(4))  bus_b ();

    counter_checker #(
        .WIDTH(8), .LOCK_CNT(A_LOCK), .UNLOCK_CNT(A_UNLOCK), .ERR_W(16)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    counter_checker #(
        .WIDTH(8), .LOCK_CNT(4), .UNLOCK_CNT(15), .ERR_W(4)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    obs_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model of instance A.
    logic        m_locked;
    logic        m_have_prev;
    int          m_run;
    int          m_miss;
    logic [7:0]  m_exp;
    logic [15:0] m_err;

    logic [7:0] wrap_seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, req);
        end
    endtask

    task automatic a_compare(input string tag, output obs_t got);
        obs_t want;
        got = {bus_a.locked, bus_a.err_pulse, bus_a.wrap_pulse, bus_a.err_cnt, bus_a.expected};
        check({tag, "/sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            want = sb_q.pop_front();
            check({tag, "/locked"},     32'(got.locked),     32'(want.locked));
            check({tag, "/err_pulse"},  32'(got.err_pulse),  32'(want.err_pulse));
            check({tag, "/wrap_pulse"}, 32'(got.wrap_pulse), 32'(want.wrap_pulse));
            check({tag, "/err_cnt"},    32'(got.err_cnt),    32'(want.err_cnt));
            check({tag, "/expected"},   32'(got.expected),   32'(want.expected));
        end
    endtask

    task automatic a_reset(input string tag);
        obs_t got;
        m_locked = 1'b0; m_have_prev = 1'b0; m_run = 0; m_miss = 0;
        m_exp = 8'h00; m_err = 16'h0000;
        sb_q.push_back('0);
        rst_a = 1'b1;
        bus_a.sample_en = 1'b1;
        bus_a.clr_err   = 1'b1;
        bus_a.cmpt_in   = 8'h5A;
        @(posedge clk);
        #1;
        a_compare(tag, got);
        $display("A %s: rst -> locked=%0b err=%0d exp=0x%02h", tag, got.locked, got.err_cnt, got.expected);
        rst_a = 1'b0;
        bus_a.sample_en = 1'b0;
        bus_a.clr_err   = 1'b0;
    endtask

    task automatic a_step(input string tag, input logic [7:0] cin, input logic en,
                          input logic clr, output obs_t got);
        logic match;
        logic inc;
        logic errp;
        logic wrp;
        obs_t want;
        inc = 1'b0; errp = 1'b0; wrp = 1'b0;
        if (en) begin
            match = m_have_prev && (cin == m_exp);
            if (!m_locked) begin
                if (!match) m_run = 0;
                else if (m_run + 1 == A_LOCK) begin
                    m_locked = 1'b1; m_run = 0; m_miss = 0;
                end else m_run = m_run + 1;
            end else begin
                if (match) begin
                    m_miss = 0;
                    wrp = (cin == 8'h00);
                end else begin
                    errp = 1'b1; inc = 1'b1;
                    m_miss = m_miss + 1;
                    if (m_miss == A_UNLOCK) begin
                        m_locked = 1'b0; m_run = 0; m_miss = 0;
                    end
                end
            end
            m_exp = cin + 8'd1;
            m_have_prev = 1'b1;
        end
        if (clr) m_err = inc ? 16'd1 : 16'd0;
        else if (inc && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        want = {m_locked, errp, wrp, m_err, m_exp};
        sb_q.push_back(want);
        bus_a.cmpt_in   = cin;
        bus_a.sample_en = en;
        bus_a.clr_err   = clr;
        @(posedge clk);
        #1;
        a_compare(tag, got);
        $display("A %s: in=0x%02h en=%0b clr=%0b -> locked=%0b errp=%0b wrapp=%0b err=%0d exp=0x%02h",
                 tag, cin, en, clr, got.locked, got.err_pulse, got.wrap_pulse, got.err_cnt, got.expected);
        bus_a.sample_en = 1'b0;
        bus_a.clr_err   = 1'b0;
    endtask

    task automatic b_step(input logic [7:0] cin, input logic en, input logic clr);
        bus_b.cmpt_in   = cin;
        bus_b.sample_en = en;
        bus_b.clr_err   = clr;
        @(posedge clk);
        #1;
        $display("B: in=0x%02h en=%0b clr=%0b -> locked=%0b errp=%0b wrapp=%0b err=%0d exp=0x%02h",
                 cin, en, clr, bus_b.locked, bus_b.err_pulse, bus_b.wrap_pulse, bus_b.err_cnt, bus_b.expected);
        bus_b.sample_en = 1'b0;
        bus_b.clr_err   = 1'b0;
    endtask

    initial begin
        obs_t got;
        int   wraps;
        int   errs;
        logic [7:0] v;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.cmpt_in = 8'h00; bus_a.sample_en = 1'b0; bus_a.clr_err = 1'b0;
        bus_b.cmpt_in = 8'h00; bus_b.sample_en = 1'b0; bus_b.clr_err = 1'b0;

        // Reset state.
        a_reset("reset0");

        // Lock-in on 5..9.
        for (int i = 5; i <= 9; i++) a_step($sformatf("lockin_%0d", i), 8'(i), 1'b1, 1'b0, got);
        check("lockin/locked",   32'(got.locked),   32'd1);
        check("lockin/err_cnt",  32'(got.err_cnt),  32'd0);
        check("lockin/expected", 32'(got.expected), 32'h0A);

        // Wrap 0xFF -> 0x00 while locked.
        a_reset("reset_wrap");
        for (int i = 0; i < 5; i++) a_step("wrap_lock", 8'(8'hF9 + i), 1'b1, 1'b0, got);
        check("wrap/locked_pre", 32'(got.locked), 32'd1);
        wraps = 0; errs = 0;
        for (int i = 0; i < 4; i++) begin
            v = wrap_seq[i];
            a_step($sformatf("wrap_%02h", v), v, 1'b1, 1'b0, got);
            check($sformatf("wrap_%02h/pulse", v), 32'(got.wrap_pulse), 32'(v == 8'h00));
            wraps += int'(got.wrap_pulse);
            errs  += int'(got.err_pulse);
        end
        check("wrap/count",    32'(wraps), 32'd1);
        check("wrap/no_err",   32'(errs),  32'd0);

        // Single error keeps lock.
        a_reset("reset_single");
        for (int i = 0; i < 5; i++) a_step("single_lock", 8'(8'h1C + i), 1'b1, 1'b0, got);
        a_step("single_22", 8'h22, 1'b1, 1'b0, got);
        check("single/err_pulse", 32'(got.err_pulse), 32'd1);
        a_step("single_23", 8'h23, 1'b1, 1'b0, got);
        check("single/err_cnt", 32'(got.err_cnt), 32'd1);
        check("single/locked",  32'(got.locked),  32'd1);

        // Clear with sample_en low, then lose lock on two bad steps.
        a_step("clr_idle", 8'hC3, 1'b0, 1'b1, got);
        check("clr_idle/err_cnt",  32'(got.err_cnt),  32'd0);
        check("clr_idle/expected", 32'(got.expected), 32'h24);
        errs = 0;
        a_step("loss_10", 8'h10, 1'b1, 1'b0, got); errs += int'(got.err_pulse);
        a_step("loss_40", 8'h40, 1'b1, 1'b0, got); errs += int'(got.err_pulse);
        a_step("loss_70", 8'h70, 1'b1, 1'b0, got); errs += int'(got.err_pulse);
        check("loss/pulses",  32'(errs),          32'd2);
        check("loss/err_cnt", 32'(got.err_cnt),   32'd2);
        check("loss/locked",  32'(got.locked),    32'd0);
        for (int i = 1; i <= 5; i++) begin
            a_step($sformatf("relock_%02h", 8'(8'h70 + i)), 8'(8'h70 + i), 1'b1, 1'b0, got);
            check($sformatf("relock_%02h/locked", 8'(8'h70 + i)), 32'(got.locked), 32'(i >= 4));
        end
        check("relock/err_cnt", 32'(got.err_cnt), 32'd2);

        // Enable gating with garbage on the bus.
        for (int i = 0; i < 3; i++) begin
            a_step($sformatf("gate_%0d", i), 8'($urandom_range(255)), 1'b0, 1'b0, got);
            check($sformatf("gate_%0d/expected", i), 32'(got.expected), 32'h76);
        end

        // Clear concurrent with a mismatch, then a source reset to 0.
        a_step("clr_hit", 8'h99, 1'b1, 1'b1, got);
        check("clr_hit/err_cnt",   32'(got.err_cnt),   32'd1);
        check("clr_hit/err_pulse", 32'(got.err_pulse), 32'd1);
        a_step("src_zero", 8'h00, 1'b1, 1'b0, got);
        check("src_zero/wrap_pulse", 32'(got.wrap_pulse), 32'd0);
        check("src_zero/err_cnt",    32'(got.err_cnt),    32'd2);

        // Mid-stream reset overrides enable and clear; next sample anchors.
        a_reset("reset_mid");
        a_step("anchor_30", 8'h30, 1'b1, 1'b0, got);
        check("anchor/expected", 32'(got.expected), 32'h31);
        check("anchor/err_pulse", 32'(got.err_pulse), 32'd0);

        // Instance B: reset state after being held in reset.
        check("b_reset/locked",  32'(bus_b.locked),  32'd0);
        check("b_reset/err_cnt", 32'(bus_b.err_cnt), 32'd0);
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) b_step(8'(i), 1'b1, 1'b0);
        check("b_lock/locked", 32'(bus_b.locked), 32'd1);

        // 20 isolated mismatches, each followed by a good step, saturate at 15.
        for (int i = 0; i < 20; i++) begin
            v = 8'(8'h10 + 16 * i);
            b_step(v, 1'b1, 1'b0);
            check($sformatf("b_sat_%0d/err_pulse", i), 32'(bus_b.err_pulse), 32'd1);
            check($sformatf("b_sat_%0d/err_cnt", i), 32'(bus_b.err_cnt), 32'((i + 1 > 15) ? 15 : i + 1));
            b_step(v + 8'd1, 1'b1, 1'b0);
            check($sformatf("b_sat_%0d/locked", i), 32'(bus_b.locked), 32'd1);
        end
        check("b_sat/final", 32'(bus_b.err_cnt), 32'd15);

        // Mid-run reset on B with enable and clear asserted.
        rst_b = 1'b1;
        b_step(8'h77, 1'b1, 1'b1);
        rst_b = 1'b0;
        check("b_rst/locked",     32'(bus_b.locked),     32'd0);
        check("b_rst/err_cnt",    32'(bus_b.err_cnt),    32'd0);
        check("b_rst/expected",   32'(bus_b.expected),   32'd0);
        check("b_rst/err_pulse",  32'(bus_b.err_pulse),  32'd0);
        check("b_rst/wrap_pulse", 32'(bus_b.wrap_pulse), 32'd0);
        b_step(8'h30, 1'b1, 1'b0);
        check("b_anchor/expected", 32'(bus_b.expected), 32'h31);
        check("b_anchor/err_pulse", 32'(bus_b.err_pulse), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            b_step(8'(8'h30 + i), 1'b1, 1'b0);
            check($sformatf("b_relock_%0d/locked", i), 32'(bus_b.locked), 32'(i == 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
